// File: rtl/tetris_2048_pkg.sv
// Shared definitions for the tetris_2048 command scheduler.
// Holds the 2-bit command codes carried in the command FIFO and the
// issuer FSM state encoding.
package tetris_2048_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_L    = 2'd1,
        CMD_R    = 2'd2,
        CMD_DROP = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } iss_state_t;

endpackage

// File: rtl/tetris_2048_debounce.sv
// One push-button conditioner: 2-flop synchronizer followed by a
// consecutive-sample debouncer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button, active-high
//   level    : debounced level
module tetris_2048_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            // cnt counts consecutive samples that disagree with level; the
            // flip happens on the DEBOUNCE_CYCLES-th such sample.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_2048_cmd_sched.sv
// Command scheduler between the board buttons and tetris_2048_core.
// Debounces three buttons, turns presses into queued commands, and issues
// them as single-cycle pulses spaced so the core can finish each action.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   btn_l, btn_r, btn_drop    : raw buttons, active-high
//   core_busy                 : core still processing a drop/merge
//   game_over                 : flushes the queue and freezes issuing
//   core_btn_l/_r/_drop       : registered command pulses to the core
//   fifo_count                : number of queued commands
//   overflow                  : sticky, a command was dropped on a full FIFO
module tetris_2048_cmd_sched
    import tetris_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 4,
    parameter int MOVE_GAP        = 2,
    parameter int DROP_GAP        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_l,
    input  logic                       btn_r,
    input  logic                       btn_drop,
    input  logic                       core_busy,
    input  logic                       game_over,
    output logic                       core_btn_l,
    output logic                       core_btn_r,
    output logic                       core_btn_drop,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int GMAX = (MOVE_GAP > DROP_GAP) ? MOVE_GAP : DROP_GAP;
    localparam int GW   = (GMAX < 2) ? 1 : $clog2(GMAX + 1);

    // Button conditioning
    logic lvl_l, lvl_r, lvl_drop;

    tetris_2048_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .rst(rst), .btn(btn_l), .level(lvl_l));
    tetris_2048_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .rst(rst), .btn(btn_r), .level(lvl_r));
    tetris_2048_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_drop (
        .clk(clk), .rst(rst), .btn(btn_drop), .level(lvl_drop));

    // Press detection and arbitration; bit order is {drop, l, r}
    logic [2:0] lvl_q, press, pend, cand, grant;
    cmd_t       push_cmd;

    assign press = {lvl_drop, lvl_l, lvl_r} & ~lvl_q;
    // A fresh event competes in the same cycle it occurs so the enqueue
    // lands at the end of the debounced-rise cycle.
    assign cand  = pend | press;

    always_comb begin
        grant    = 3'b000;
        push_cmd = CMD_NONE;
        if (cand[2]) begin
            grant    = 3'b100;
            push_cmd = CMD_DROP;
        end else if (cand[1]) begin
            grant    = 3'b010;
            push_cmd = CMD_L;
        end else if (cand[0]) begin
            grant    = 3'b001;
            push_cmd = CMD_R;
        end
    end

    // Command FIFO
    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push_req, push;
    iss_state_t    state;

    assign full     = (fifo_count == CW'(DEPTH));
    assign pop      = (state == IDLE) && (fifo_count != '0) && !game_over;
    assign push_req = (grant != 3'b000) && !game_over;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q      <= 3'b000;
            pend       <= 3'b000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            lvl_q <= {lvl_drop, lvl_l, lvl_r};
            if (game_over) begin
                pend       <= 3'b000;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                // The granted flag clears whether the push lands or is lost.
                pend <= cand & ~grant;
                if (push)            wr_ptr   <= wr_ptr + 1'b1;
                if (pop)             rd_ptr   <= rd_ptr + 1'b1;
                if (push_req && !push) overflow <= 1'b1;
                if (push && !pop)      fifo_count <= fifo_count + 1'b1;
                else if (pop && !push) fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Issuer FSM
    logic [GW-1:0] gap_cnt, gap_next;
    cmd_t          head;

    assign head     = mem[rd_ptr];
    assign gap_next = (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            core_btn_l    <= 1'b0;
            core_btn_r    <= 1'b0;
            core_btn_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state         <= ISSUE;
                        core_btn_l    <= (head == CMD_L);
                        core_btn_r    <= (head == CMD_R);
                        core_btn_drop <= (head == CMD_DROP);
                    end
                end
                ISSUE: begin
                    state         <= GAP;
                    gap_cnt       <= core_btn_drop ? GW'(DROP_GAP) : GW'(MOVE_GAP);
                    core_btn_l    <= 1'b0;
                    core_btn_r    <= 1'b0;
                    core_btn_drop <= 1'b0;
                end
                GAP: begin
                    // Leave once the count reaches zero and the core is free;
                    // this gives pulse spacing of gap + 2 cycles.
                    gap_cnt <= gap_next;
                    if (gap_next == '0 && !core_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tetris_2048_cmd_sched.md
# tetris_2048_cmd_sched

Command scheduler between the board push-buttons and `tetris_2048_core`. It synchronizes and debounces the raw `btn_l`, `btn_r` and `btn_drop` inputs, then turns each press into one command held in a small FIFO. It issues the commands to the core as single-cycle pulses, spaced so the core finishes each drop/merge before the next command arrives. The core therefore never sees bounce, held buttons or back-to-back pulses.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable synchronized samples required to change a debounced level (5 ms at 100 MHz).
- `DEPTH`, default 4: command FIFO depth; must be a power of two and at least 2.
- `MOVE_GAP`, default 2: idle cycles after an L/R pulse.
- `DROP_GAP`, default 8: minimum idle cycles after a drop pulse.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `btn_l`, `btn_r`, `btn_drop` in 1 each: raw asynchronous buttons, active-high.
- `core_busy` in 1: high while the core is processing a drop or merge.
- `game_over` in 1: from the core.
- `core_btn_l`, `core_btn_r`, `core_btn_drop` out 1 each: registered pulses to the core.
- `fifo_count` out `$clog2(DEPTH+1)`: number of queued commands.
- `overflow` out 1: sticky; set when a command is discarded because the FIFO is full.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level takes the synchronized value once that value has differed from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce during the count resets the counter.
- A press event is the rising edge of a debounced level. A held button produces exactly one event, and releases produce none.
- Pending flags and arbitration:
  - Each press event sets a pending flag for that button.
  - At most one pending flag is enqueued per cycle, in fixed priority drop > left > right.
  - Flags that lose arbitration stay set and enqueue on later cycles, in the same priority order.
- FIFO behaviour:
  - The FIFO holds 2-bit command codes.
  - A push when full is accepted only if a pop occurs in the same cycle.
  - Otherwise the command is discarded, its pending flag is cleared, and `overflow` is set.
- Issuer FSM has three states: IDLE, ISSUE, GAP.
  - IDLE → ISSUE when the FIFO is non-empty and `game_over` is 0. The head entry is popped on this transition.
  - ISSUE lasts one cycle. Exactly one `core_btn_*` output matching the popped command is high.
  - ISSUE → GAP, with the gap counter loaded with `MOVE_GAP` (for L/R) or `DROP_GAP` (for drop).
  - GAP → IDLE when the counter reaches 0 and `core_busy` is 0. If `core_busy` is still high at count 0, the FSM stays in GAP until it falls.
- `game_over` handling, while `game_over` is 1:
  - The FIFO and pending flags are cleared.
  - New events are ignored, and `overflow` is not set by them.
  - IDLE does not leave. A command already in ISSUE or GAP completes normally.
- Left at column 0 and right at column 3 are still issued; clamping is the core's job.

## Timing
- Reset values: all `core_btn_*` 0; `fifo_count` 0; `overflow` 0; FSM in IDLE; debounced levels 0; counters 0; pending flags 0; synchronizers 0.
- Press latency:
  - A raw edge reaches the synchronized signal 2 cycles later.
  - The debounced level rises `DEBOUNCE_CYCLES` cycles after that.
  - The press event occurs in the same cycle as the debounced rise.
  - The enqueue registers at the end of that cycle.
  - The FSM pops into ISSUE in the next cycle, and `core_btn_*` is high in the cycle after the pop edge.
  - With an empty FIFO and the FSM in IDLE, the delay from debounced rise to pulse is 2 cycles.
- Minimum spacing between two issued pulses:
  - After L/R: `MOVE_GAP` + 2 cycles.
  - After drop: `DROP_GAP` + 2 cycles, or longer if `core_busy` holds.
- `fifo_count` updates the cycle after each push or pop; a simultaneous push and pop leaves it unchanged.
- FIFO read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Reset asserted mid-operation forces the reset state on the next edge. A pulse in flight is deasserted on that edge.

## Structure
- Package `tetris_2048_pkg` holds:
  - Command codes: `CMD_NONE` = 0, `CMD_L` = 1, `CMD_R` = 2, `CMD_DROP` = 3.
  - The issuer state encoding: IDLE = 0, ISSUE = 1, GAP = 2.
- Sub-module `tetris_2048_debounce` contains one synchronizer plus the debounce counter and outputs the debounced level. It is instantiated three times.
- The FIFO, arbitration logic and FSM live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `DEPTH` = 4, `MOVE_GAP` = 2, `DROP_GAP` = 8.
- Bounce rejection: `btn_drop` toggles 1/0 every 2 cycles for 20 cycles, then holds 1 for 40 cycles → exactly one `core_btn_drop` pulse, 1 cycle wide, 8 cycles after the hold starts.
- Simultaneous press: all three buttons rise in the same cycle → pulses issue in order drop, L, R. The L pulse comes ≥10 cycles after the drop pulse, and the R pulse ≥4 cycles after L.
- Busy hold: `core_busy` is high for 30 cycles starting 1 cycle after the drop pulse, and an L press is queued → the L pulse appears 2 cycles after `core_busy` falls.
- Overflow: hold `core_busy` = 1 after a drop, then make 6 L presses → `fifo_count` saturates at 4, `overflow` = 1 and stays 1. Four L pulses follow once busy clears.
- Game over: queue 3 commands, then assert `game_over` → `fifo_count` = 0 on the next cycle, no further pulses, and new presses are ignored.
- Reset mid-GAP: assert `rst` 3 cycles after a drop pulse → the next cycle shows all outputs 0, `fifo_count` = 0 and the FSM in IDLE.
